// File: rtl/packet_merger_if.sv
// Packet handshake bundle for the two-input merger: two receive ports with
// VALID/DATA in and a READY pulse out, plus the merged send port.
interface packet_merger_if #(
  parameter int PACKET_WIDTH = 175
);
  logic                    RECEIVE_PC0_VALID;
  logic [PACKET_WIDTH-1:0] RECEIVE_PC0_DATA;
  logic                    RECEIVE_PC0_READY;
  logic                    RECEIVE_PC1_VALID;
  logic [PACKET_WIDTH-1:0] RECEIVE_PC1_DATA;
  logic                    RECEIVE_PC1_READY;
  logic                    SEND_PC_VALID;
  logic [PACKET_WIDTH-1:0] SEND_PC_DATA;
  logic                    SEND_PC_READY;

  modport slave (
    input  RECEIVE_PC0_VALID, RECEIVE_PC0_DATA,
    output RECEIVE_PC0_READY,
    input  RECEIVE_PC1_VALID, RECEIVE_PC1_DATA,
    output RECEIVE_PC1_READY,
    output SEND_PC_VALID, SEND_PC_DATA,
    input  SEND_PC_READY
  );

  modport master (
    output RECEIVE_PC0_VALID, RECEIVE_PC0_DATA,
    input  RECEIVE_PC0_READY,
    output RECEIVE_PC1_VALID, RECEIVE_PC1_DATA,
    input  RECEIVE_PC1_READY,
    input  SEND_PC_VALID, SEND_PC_DATA,
    output SEND_PC_READY
  );
endinterface

// File: rtl/packet_merger.sv
// Two-input round-robin packet merger with a single packet buffer and
// per-input forwarded-packet counters.
module packet_merger #(
  parameter int PACKET_WIDTH = 175,
  parameter int COUNT_WIDTH  = 32
) (
  input  logic                   CLK,
  input  logic                   RST,
  packet_merger_if.slave         bus,
  output logic [COUNT_WIDTH-1:0] COUNT0,
  output logic [COUNT_WIDTH-1:0] COUNT1
);
  typedef enum logic [1:0] {S_IDLE, S_ACK, S_SEND} state_t;

  state_t                  state_q;
  logic                    grant_q;
  logic                    last_q;
  logic                    rdy0_q;
  logic                    rdy1_q;
  logic                    send_valid_q;
  logic [PACKET_WIDTH-1:0] send_data_q;
  logic [COUNT_WIDTH-1:0]  count0_q;
  logic [COUNT_WIDTH-1:0]  count1_q;

  logic                    grant_d;
  logic                    granted_valid;
  logic [PACKET_WIDTH-1:0] granted_data;

  // On a tie the input that was not forwarded last wins.
  always_comb begin
    grant_d = bus.RECEIVE_PC1_VALID;
    if (bus.RECEIVE_PC0_VALID && bus.RECEIVE_PC1_VALID) begin
      grant_d = ~last_q;
    end
    granted_valid = grant_q ? bus.RECEIVE_PC1_VALID : bus.RECEIVE_PC0_VALID;
    granted_data  = grant_q ? bus.RECEIVE_PC1_DATA  : bus.RECEIVE_PC0_DATA;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= S_IDLE;
      grant_q      <= 1'b0;
      last_q       <= 1'b1;
      rdy0_q       <= 1'b0;
      rdy1_q       <= 1'b0;
      send_valid_q <= 1'b0;
      send_data_q  <= '0;
      count0_q     <= '0;
      count1_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.RECEIVE_PC0_VALID || bus.RECEIVE_PC1_VALID) begin
            grant_q <= grant_d;
            rdy0_q  <= ~grant_d;
            rdy1_q  <= grant_d;
            state_q <= S_ACK;
          end
        end
        S_ACK: begin
          rdy0_q <= 1'b0;
          rdy1_q <= 1'b0;
          // A sender that dropped VALID under its READY gets nothing captured.
          if (granted_valid) begin
            send_data_q  <= granted_data;
            send_valid_q <= 1'b1;
            last_q       <= grant_q;
            if (grant_q) begin
              count1_q <= count1_q + 1'b1;
            end else begin
              count0_q <= count0_q + 1'b1;
            end
            state_q <= S_SEND;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_SEND: begin
          if (bus.SEND_PC_READY) begin
            send_valid_q <= 1'b0;
            state_q      <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.RECEIVE_PC0_READY = rdy0_q;
  assign bus.RECEIVE_PC1_READY = rdy1_q;
  assign bus.SEND_PC_VALID     = send_valid_q;
  assign bus.SEND_PC_DATA      = send_data_q;
  assign COUNT0                = count0_q;
  assign COUNT1                = count1_q;
endmodule
